m_vector_fetcher: RTL and testbench
===================================

Name: m_vector_fetcher

Overview:
Parametrised fetch sequencer that streams filter-vector elements from a single-port vector memory to the MAC datapath. It walks a sweep of layers and column tiles, issuing one burst of FILTER_LEN reads per request. Fixed-latency read data is buffered in an output FIFO with valid/ready handshake, so the consumer can stall without dropping elements. Column ordering is selectable: bit-interleaved quadrant order or linear order.

Parameters:
DATA_W, 16, element width
ADDR_W, 10, memory address width; address = {row, col}
COL_BITS, 4, column field width (even); ROW_W = ADDR_W-COL_BITS
LAYERS, 4, bursts per tile (power of 2, >=2)
FILTER_LEN, 8, elements per burst (>=1)
ROW_STRIDE, 4, row increment between consecutive elements
MEM_LAT, 1, cycles from sampled mem_en to valid mem_rdata (>=1)
FIFO_DEPTH, 4, output buffer entries (power of 2, >=2)

Ports:
clock  in  1  rising-edge clock
clear_n  in  1  reset, asynchronous, active-low
start  in  1  request one burst; sampled only in IDLE
restart  in  1  in IDLE: zero layer/tile counters; ignored otherwise
interleave  in  1  1 = quadrant-interleaved column, 0 = linear; sampled at start
mem_rdata  in  DATA_W  memory read data
mem_addr  out  ADDR_W  registered read address
mem_en  out  1  registered read enable
mem_write  out  1  tied 0
out_valid  out  1  FIFO non-empty
out_ready  in  1  consumer accepts out_data when out_valid
out_data  out  DATA_W  head-of-FIFO element (show-ahead)
out_last  out  1  head element is last of its burst
burst_done  out  1  one-cycle pulse when final element of a burst is accepted
sweep_last  out  1  high while layer==LAYERS-1 and tile==2^COL_BITS-1
busy  out  1  state != IDLE

Behaviour:
- Reset (clear_n low, asynchronous): state IDLE; layer, tile, issue index, inflight pipeline, FIFO pointers all 0; mem_en, mem_addr, out_valid, out_last, burst_done, busy = 0; out_data = 0. Reads in flight at reset are discarded.
- States: IDLE -> ISSUE on start; ISSUE -> DRAIN after issuing element FILTER_LEN-1; DRAIN -> IDLE on the edge where the burst's last element is accepted (burst_done pulses in the following cycle). start/restart outside IDLE ignored. start and restart together in IDLE: restart applied first, burst uses layer=0, tile=0.
- Issue rule: in ISSUE, one read per cycle when (fifo_count + inflight) < FIFO_DEPTH; otherwise mem_en=0 and issue index holds. FIFO can never overflow.
- Address for element k (0..FILTER_LEN-1): row = ROW_STRIDE*(k+1) + layer, modulo 2^ROW_W. Tile = {major, minor}, each COL_BITS/2 bits. interleave=1: col[2i]=minor[i], col[2i+1]=major[i]; interleave=0: col = tile.
- Read pipeline: MEM_LAT-deep shift of {valid, last}; mem_rdata written to FIFO in the cycle its valid bit emerges. No write-side stall exists (credit guaranteed).
- Output: pop on out_valid && out_ready. Push and pop may occur in the same cycle (count unchanged). Empty FIFO: out_valid=0, out_data holds the last value.
- Counter advance at burst end (DRAIN->IDLE): layer+1; on layer wrap, tile+1; on tile wrap, sweep restarts at 0. No wait for restart.
- Latency, out_ready=1: first mem_en in the cycle after the start edge; first out_valid MEM_LAT+2 edges after the start edge; then one element per clock.

Test Plan:
- Reset: assert clear_n=0 mid-ISSUE with 2 reads in flight -> out_valid, mem_en, busy drop immediately; after release no stale data appears; next burst addresses restart at layer 0.
- Single burst, defaults, out_ready=1, interleave=1 -> mem_addr 0x040,0x080,...,0x200 on 8 consecutive cycles; out_data equals the memory contents in order; out_last on 8th; burst_done one cycle; out_valid first at start edge +3.
- Backpressure: out_ready=0 throughout burst -> exactly 4 mem_en pulses, then stall; raise out_ready -> remaining 4 issued, all 8 delivered in order, none lost or duplicated.
- Sweep order: 4 bursts -> row bases 4,5,6,7 (first addr 0x040,0x050,0x060,0x070); 5th burst tile=1 -> col=1 (addr 0x041); tile=2 -> col=4; tile=4 -> col=2.
- Wrap and restart: run 64 bursts -> sweep_last high only during the 64th; 65th burst addresses from 0x040; restart pulse after burst 3 -> next burst first addr 0x040.
- interleave=0 with tile=2 -> col=2 (first addr 0x042); random out_ready toggling over full sweep -> scoreboard match, FIFO never exceeds 4.

Source files
------------

// File: rtl/m_vector_fetcher.sv
// ---------------------------------------------------------------------------
// m_vector_fetcher
//
// Fetch sequencer that streams filter-vector elements from a single-port
// vector memory to the MAC datapath. Each start request issues one burst of
// FILTER_LEN reads for the current (layer, tile). Fixed-latency read data is
// collected in a small show-ahead FIFO with a valid/ready handshake. A credit
// check on reads in flight keeps the FIFO from overflowing. Layer and tile
// counters step through a full sweep and then wrap back to the start.
//
// Ports:
//   clock       rising-edge clock
//   clear_n     asynchronous active-low reset
//   start       request one burst (sampled in IDLE only)
//   restart     in IDLE: zero the layer/tile counters
//   interleave  1 = quadrant-interleaved column, 0 = linear (sampled at start)
//   mem_rdata   memory read data, valid MEM_LAT cycles after a sampled read
//   mem_addr    registered read address {row, col}
//   mem_en      registered read enable
//   mem_write   always 0
//   out_valid   FIFO non-empty
//   out_ready   consumer accepts out_data
//   out_data    head-of-FIFO element (holds last value when empty)
//   out_last    head element is the last one of its burst
//   burst_done  one-cycle pulse after the last element of a burst is accepted
//   sweep_last  current counters are the final layer of the final tile
//   busy        sequencer not idle
// ---------------------------------------------------------------------------
module m_vector_fetcher #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned COL_BITS   = 4,
    parameter int unsigned LAYERS     = 4,
    parameter int unsigned FILTER_LEN = 8,
    parameter int unsigned ROW_STRIDE = 4,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clock,
    input  logic              clear_n,
    input  logic              start,
    input  logic              restart,
    input  logic              interleave,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_en,
    output logic              mem_write,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              burst_done,
    output logic              sweep_last,
    output logic              busy
);

    localparam int unsigned ROW_W   = ADDR_W - COL_BITS;
    localparam int unsigned HALF    = COL_BITS / 2;
    localparam int unsigned LAYER_W = $clog2(LAYERS);
    localparam int unsigned IDX_W   = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    // Wide enough for fifo count plus every read that can be in flight.
    localparam int unsigned CRED_W  = $clog2(FIFO_DEPTH + MEM_LAT + 2) + 1;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StIssue = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;

    // Sequencer state
    logic [1:0]          state_q, state_d;
    logic [LAYER_W-1:0]  layer_q, layer_d;
    logic [COL_BITS-1:0] tile_q, tile_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [COL_BITS-1:0] col_q, col_d;

    // Read request and return pipeline
    logic                mem_en_q, mem_en_d;
    logic                mem_last_q, mem_last_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [MEM_LAT-1:0]  pipe_valid_q;
    logic [MEM_LAT-1:0]  pipe_last_q;

    // Output FIFO
    logic [DATA_W-1:0]   fifo_data_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_last_q;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [DATA_W-1:0]   hold_q, hold_d;
    logic                burst_done_q, burst_done_d;

    logic                push;
    logic                pop;
    logic                head_last;
    logic                credit_ok;
    logic [CRED_W-1:0]   inflight;

    // Quadrant interleave: minor bits land on even column bits, major on odd.
    function automatic logic [COL_BITS-1:0] map_col(input logic [COL_BITS-1:0] tile,
                                                    input logic il);
        logic [COL_BITS-1:0] col;
        col = tile;
        if (il) begin
            for (int i = 0; i < int'(HALF); i++) begin
                col[2*i]   = tile[i];
                col[2*i+1] = tile[HALF+i];
            end
        end
        return col;
    endfunction

    assign out_valid  = (count_q != '0);
    assign pop        = out_valid && out_ready;
    assign push       = pipe_valid_q[MEM_LAT-1];
    assign head_last  = fifo_last_q[rd_ptr_q];
    assign out_data   = out_valid ? fifo_data_q[rd_ptr_q] : hold_q;
    assign out_last   = out_valid && head_last;

    assign mem_en     = mem_en_q;
    assign mem_addr   = mem_addr_q;
    assign mem_write  = 1'b0;
    assign burst_done = burst_done_q;
    assign busy       = (state_q != StIdle);
    assign sweep_last = (layer_q == LAYER_W'(LAYERS - 1)) && (tile_q == '1);

    // Reads already committed: the one being presented now plus the return pipe.
    always_comb begin
        inflight = CRED_W'(mem_en_q);
        for (int i = 0; i < int'(MEM_LAT); i++) begin
            inflight = inflight + CRED_W'(pipe_valid_q[i]);
        end
    end

    // Pops in the same cycle are not credited, which keeps the check simple
    // and still sustains one read per clock at the defaults.
    assign credit_ok = (CRED_W'(count_q) + inflight) < CRED_W'(FIFO_DEPTH);

    // Sequencer next state
    always_comb begin
        state_d      = state_q;
        layer_d      = layer_q;
        tile_d       = tile_q;
        idx_d        = idx_q;
        row_d        = row_q;
        col_d        = col_q;
        mem_en_d     = 1'b0;
        mem_last_d   = 1'b0;
        mem_addr_d   = mem_addr_q;
        burst_done_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (restart) begin
                    layer_d = '0;
                    tile_d  = '0;
                end
                if (start) begin
                    state_d = StIssue;
                    idx_d   = '0;
                    // Row of element 0 is ROW_STRIDE + layer; later rows add the stride.
                    row_d   = ROW_W'(ROW_STRIDE) + ROW_W'(layer_d);
                    col_d   = map_col(tile_d, interleave);
                end
            end
            StIssue: begin
                if (credit_ok) begin
                    mem_en_d   = 1'b1;
                    mem_addr_d = {row_q, col_q};
                    mem_last_d = (idx_q == IDX_W'(FILTER_LEN - 1));
                    row_d      = row_q + ROW_W'(ROW_STRIDE);
                    idx_d      = idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(FILTER_LEN - 1)) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (pop && head_last) begin
                    state_d      = StIdle;
                    burst_done_d = 1'b1;
                    layer_d      = layer_q + LAYER_W'(1);
                    if (layer_q == LAYER_W'(LAYERS - 1)) begin
                        tile_d = tile_q + COL_BITS'(1);
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FIFO pointer and count next state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        hold_d   = hold_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            hold_d   = fifo_data_q[rd_ptr_q];
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q      <= StIdle;
            layer_q      <= '0;
            tile_q       <= '0;
            idx_q        <= '0;
            row_q        <= '0;
            col_q        <= '0;
            mem_en_q     <= 1'b0;
            mem_last_q   <= 1'b0;
            mem_addr_q   <= '0;
            pipe_valid_q <= '0;
            pipe_last_q  <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            hold_q       <= '0;
            burst_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            layer_q      <= layer_d;
            tile_q       <= tile_d;
            idx_q        <= idx_d;
            row_q        <= row_d;
            col_q        <= col_d;
            mem_en_q     <= mem_en_d;
            mem_last_q   <= mem_last_d;
            mem_addr_q   <= mem_addr_d;
            // The memory samples mem_en at this edge; track it until data returns.
            pipe_valid_q[0] <= mem_en_q;
            pipe_last_q[0]  <= mem_en_q && mem_last_q;
            for (int i = 1; i < int'(MEM_LAT); i++) begin
                pipe_valid_q[i] <= pipe_valid_q[i-1];
                pipe_last_q[i]  <= pipe_last_q[i-1];
            end
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            hold_q       <= hold_d;
            burst_done_q <= burst_done_d;
        end
    end

    // Storage needs no reset: out_valid gates every read of it.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= mem_rdata;
            fifo_last_q[wr_ptr_q] <= pipe_last_q[MEM_LAT-1];
        end
    end

endmodule

// File: tb/tb_m_vector_fetcher.sv
// ---------------------------------------------------------------------------
// tb_m_vector_fetcher
//
// Randomised bench for m_vector_fetcher. A behavioural model tracks the
// layer/tile sweep and derives every burst's addresses from the row/column
// rules. A memory model with MEM_LAT latency returns random contents. Each
// burst is checked for addresses, data order, last flags, completion pulse,
// FIFO occupancy bound and, where applicable, latency.
// ---------------------------------------------------------------------------
module tb_m_vector_fetcher;

    localparam int DATA_W     = 16;
    localparam int ADDR_W     = 10;
    localparam int COL_BITS   = 4;
    localparam int LAYERS     = 4;
    localparam int FILTER_LEN = 8;
    localparam int ROW_STRIDE = 4;
    localparam int MEM_LAT    = 1;
    localparam int FIFO_DEPTH = 4;
    localparam int ROW_W      = ADDR_W - COL_BITS;
    localparam int HALF       = COL_BITS / 2;
    localparam int NTILES     = 1 << COL_BITS;

    logic              clock;
    logic              clear_n;
    logic              start;
    logic              restart;
    logic              interleave;
    logic [DATA_W-1:0] mem_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_en;
    logic              mem_write;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              burst_done;
    logic              sweep_last;
    logic              busy;

    logic [DATA_W-1:0] mem [1 << ADDR_W];
    logic [DATA_W-1:0] rd_pipe [MEM_LAT];

    int n_tests = 0;
    int n_fail  = 0;
    int m_layer = 0;
    int m_tile  = 0;

    m_vector_fetcher #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .COL_BITS  (COL_BITS),
        .LAYERS    (LAYERS),
        .FILTER_LEN(FILTER_LEN),
        .ROW_STRIDE(ROW_STRIDE),
        .MEM_LAT   (MEM_LAT),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clock     (clock),
        .clear_n   (clear_n),
        .start     (start),
        .restart   (restart),
        .interleave(interleave),
        .mem_rdata (mem_rdata),
        .mem_addr  (mem_addr),
        .mem_en    (mem_en),
        .mem_write (mem_write),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .burst_done(burst_done),
        .sweep_last(sweep_last),
        .busy      (busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Synchronous memory: read sampled at the edge, data valid MEM_LAT cycles on.
    always @(posedge clock) begin
        rd_pipe[0] <= mem[mem_addr];
        for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[MEM_LAT-1];

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int model_addr(input int k, input int layer, input int tile, input bit il);
        int row, col, major, minor;
        row = (ROW_STRIDE * (k + 1) + layer) % (1 << ROW_W);
        if (il) begin
            major = tile / (1 << HALF);
            minor = tile % (1 << HALF);
            col   = 0;
            for (int i = 0; i < HALF; i++) begin
                col += ((minor >> i) & 1) * (1 << (2 * i));
                col += ((major >> i) & 1) * (1 << (2 * i + 1));
            end
        end else begin
            col = tile;
        end
        return row * NTILES + col;
    endfunction

    // mode 0: always ready, 1: random ready, 2: stalled for `hold` cycles then ready
    function automatic logic ready_for(input int mode, input int cyc, input int hold);
        if (mode == 0) return 1'b1;
        if (mode == 1) return ($urandom_range(0, 3) != 0);
        return (cyc >= hold);
    endfunction

    task automatic run_burst(input bit do_restart, input bit il, input int mode, input int hold,
                             output int first_addr);
        int exp_addr[$];
        int got_addr[$];
        int got_data[$];
        int got_last[$];
        int first_en = -1, last_en = -1, first_valid = -1, done_at = -1;
        int done_cnt = 0, hold_en = 0, max_out = 0, popped = 0;
        logic busy_after = 1'b1;
        bit exp_sweep;

        exp_sweep = (m_layer == LAYERS - 1) && (m_tile == NTILES - 1);
        check_eq("sweep_last", 32'(sweep_last), 32'(exp_sweep));
        if (do_restart) begin
            m_layer = 0;
            m_tile  = 0;
        end
        for (int k = 0; k < FILTER_LEN; k++) exp_addr.push_back(model_addr(k, m_layer, m_tile, il));

        @(negedge clock);
        start      = 1'b1;
        restart    = do_restart;
        interleave = il;
        out_ready  = ready_for(mode, 0, hold);
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(negedge clock);
            if (cyc == 1) begin
                start      = 1'b0;
                restart    = 1'b0;
                interleave = ~il;
            end
            if (mem_en) begin
                got_addr.push_back(int'(mem_addr));
                if (first_en < 0) first_en = cyc;
                last_en = cyc;
                if (cyc <= hold) hold_en++;
            end
            if (out_valid && first_valid < 0) first_valid = cyc;
            if (burst_done) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at    = cyc;
                    busy_after = busy;
                end
            end
            if (got_addr.size() - popped > max_out) max_out = got_addr.size() - popped;
            out_ready = ready_for(mode, cyc, hold);
            if (out_valid && out_ready) begin
                got_data.push_back(int'(out_data));
                got_last.push_back(int'(out_last));
                popped++;
            end
            if (done_at >= 0 && cyc >= done_at + 2) break;
        end

        check_eq("burst_done_seen", 32'(done_at >= 0), 32'd1);
        check_eq("burst_done_pulses", 32'(done_cnt), 32'd1);
        check_eq("busy_after_done", 32'(busy_after), 32'd0);
        check_eq("addr_count", 32'(got_addr.size()), 32'(FILTER_LEN));
        check_eq("data_count", 32'(got_data.size()), 32'(FILTER_LEN));
        check_eq("fifo_bound", 32'(max_out > FIFO_DEPTH), 32'd0);
        for (int k = 0; k < FILTER_LEN; k++) begin
            if (k < got_addr.size())
                check_eq($sformatf("addr[%0d]", k), 32'(got_addr[k]), 32'(exp_addr[k]));
            if (k < got_data.size()) begin
                check_eq($sformatf("data[%0d]", k), 32'(got_data[k]), 32'(mem[exp_addr[k]]));
                check_eq($sformatf("last[%0d]", k), 32'(got_last[k]), 32'(k == FILTER_LEN - 1));
            end
        end
        if (mode == 0) begin
            check_eq("first_mem_en_cycle", 32'(first_en), 32'd2);
            check_eq("first_valid_cycle", 32'(first_valid), 32'(MEM_LAT + 3));
            check_eq("issue_back_to_back", 32'(last_en - first_en), 32'(FILTER_LEN - 1));
            check_eq("done_cycle", 32'(done_at), 32'(first_valid + FILTER_LEN));
        end
        if (mode == 2) check_eq("reads_while_stalled", 32'(hold_en), 32'(FIFO_DEPTH));

        first_addr = (got_addr.size() > 0) ? got_addr[0] : -1;
        m_layer++;
        if (m_layer == LAYERS) begin
            m_layer = 0;
            m_tile  = (m_tile + 1) % NTILES;
        end
    endtask

    initial begin
        int fa;
        int any_stale;
        clear_n    = 1'b0;
        start      = 1'b0;
        restart    = 1'b0;
        interleave = 1'b1;
        out_ready  = 1'b1;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = DATA_W'($urandom);

        repeat (2) @(negedge clock);
        check_eq("rst_mem_en", 32'(mem_en), 32'd0);
        check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_last", 32'(out_last), 32'd0);
        check_eq("rst_out_data", 32'(out_data), 32'd0);
        check_eq("rst_burst_done", 32'(burst_done), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_mem_write", 32'(mem_write), 32'd0);
        clear_n = 1'b1;

        // Single burst at defaults with the consumer always ready.
        run_burst(1'b0, 1'b1, 0, 0, fa);
        check_eq("single_first_addr", 32'(fa), 32'h040);

        // Reset asserted mid-issue with reads in flight.
        @(negedge clock);
        start     = 1'b1;
        out_ready = 1'b0;
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        clear_n = 1'b0;
        #1;
        check_eq("midrst_mem_en", 32'(mem_en), 32'd0);
        check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
        check_eq("midrst_busy", 32'(busy), 32'd0);
        @(negedge clock);
        clear_n   = 1'b1;
        out_ready = 1'b1;
        any_stale = 0;
        repeat (6) begin
            @(negedge clock);
            if (out_valid || mem_en || busy) any_stale++;
        end
        check_eq("no_stale_after_rst", 32'(any_stale), 32'd0);
        m_layer = 0;
        m_tile  = 0;

        // Full sweep; first burst under backpressure, the rest with random ready.
        for (int s = 1; s <= LAYERS * NTILES; s++) begin
            run_burst(1'b0, 1'b1, (s == 1) ? 2 : 1, 12, fa);
            case (s)
                1:  check_eq("sweep1_addr", 32'(fa), 32'h040);
                2:  check_eq("sweep2_addr", 32'(fa), 32'h050);
                3:  check_eq("sweep3_addr", 32'(fa), 32'h060);
                4:  check_eq("sweep4_addr", 32'(fa), 32'h070);
                5:  check_eq("tile1_addr", 32'(fa), 32'h041);
                9:  check_eq("tile2_addr", 32'(fa), 32'h044);
                17: check_eq("tile4_addr", 32'(fa), 32'h042);
                default: ;
            endcase
        end
        run_burst(1'b0, 1'b1, 0, 0, fa);
        check_eq("wrap_addr", 32'(fa), 32'h040);
        run_burst(1'b0, 1'b1, 1, 0, fa);
        run_burst(1'b0, 1'b1, 1, 0, fa);

        // Restart pulse on its own in IDLE.
        @(negedge clock);
        restart = 1'b1;
        @(negedge clock);
        restart = 1'b0;
        m_layer = 0;
        m_tile  = 0;
        run_burst(1'b0, 1'b1, 0, 0, fa);
        check_eq("restart_addr", 32'(fa), 32'h040);

        // Mixed interleave, then linear order on tile 2.
        for (int s = 0; s < 7; s++) run_burst(1'b0, 1'($urandom_range(0, 1)), 1, 0, fa);
        run_burst(1'b0, 1'b0, 1, 0, fa);
        check_eq("linear_tile2_addr", 32'(fa), 32'h042);

        // start and restart together: restart applies first.
        run_burst(1'b1, 1'b1, 0, 0, fa);
        check_eq("start_restart_addr", 32'(fa), 32'h040);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
